// File: rtl/vga_pkg.sv
// Purpose: shared VGA timing defaults, coordinate and colour types.
// Latency: none (types and constants only).
// Backpressure: none.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_scan_driver_if.sv
// Purpose: bundles scan coordinates, render strobes, renderer RGB and VGA pins.
// Latency: none (wiring only).
// Backpressure: none; every signal is sampled or driven every pixel clock.
interface vga_scan_if;
    import vga_pkg::*;

    coord_t     DrawX;
    coord_t     DrawY;
    logic       blank;
    logic       frame_start;
    logic       line_start;
    logic [3:0] red_in;
    logic [3:0] green_in;
    logic [3:0] blue_in;
    logic       hs;
    logic       vs;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    // Timing master side: owns coordinates and pins, consumes renderer colour.
    modport master (
        output DrawX, DrawY, blank, frame_start, line_start,
        output hs, vs, red, green, blue,
        input  red_in, green_in, blue_in
    );

    // Renderer / monitor side.
    modport slave (
        input  DrawX, DrawY, blank, frame_start, line_start,
        input  hs, vs, red, green, blue,
        output red_in, green_in, blue_in
    );

endinterface

// File: rtl/vga_delay_line.sv
// Purpose: fixed-depth shift register with a parameterised reset value.
// Latency: DEPTH clocks from din to dout.
// Backpressure: none; shifts every clock.
module vga_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; reset loads every stage with the idle value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// Purpose: VGA scan counters, render strobes, latency-matched sync/blank and pin drive.
// Latency: decodes are zero-latency on the counters; pins reflect a coordinate PIPE_DLY+1 clocks later.
// Backpressure: none; renderer RGB is sampled unconditionally every clock.
module vga_scan_driver #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_pkg::H_FRONT,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_pkg::V_FRONT,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BACK,
    parameter int PIPE_DLY = 1   // renderer latency, legal 1..4
) (
    input  logic       vga_clk,
    input  logic       reset,
    vga_scan_if.master bus
);
    import vga_pkg::*;

    localparam int     H_SUM  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_SUM  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_LAST = coord_t'(H_SUM - 1);
    localparam coord_t V_LAST = coord_t'(V_SUM - 1);
    localparam coord_t H_VIS  = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FRONT);
    localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FRONT);
    localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FRONT + V_SYNC);

    coord_t  hc;
    coord_t  vc;
    logic    blank_raw;
    logic    hs_raw;
    logic    vs_raw;
    logic    hs_dly;
    logic    vs_dly;
    logic    blank_dly;
    rgb444_t pix_in;
    rgb444_t pix_q;
    logic    hs_q;
    logic    vs_q;

    // Raster counters: hc every clock, vc on the hc wrap; both wrap on the same edge at frame end.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? coord_t'(0) : vc + coord_t'(1);
        end else begin
            hc <= hc + coord_t'(1);
        end
    end

    // Zero-latency decodes straight off the counter registers.
    assign blank_raw = (hc < H_VIS) && (vc < V_VIS);
    assign hs_raw    = !((hc >= HS_BEG) && (hc < HS_END));
    assign vs_raw    = !((vc >= VS_BEG) && (vc < VS_END));

    // Sync and enable are held back by the renderer latency so they meet the matching RGB.
    vga_delay_line #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL (3'b110)
    ) u_dly (
        .clk  (vga_clk),
        .rst  (reset),
        .din  ({hs_raw, vs_raw, blank_raw}),
        .dout ({hs_dly, vs_dly, blank_dly})
    );

    assign pix_in = '{r: bus.red_in, g: bus.green_in, b: bus.blue_in};

    // Pin register: colour forced to black outside the active area regardless of renderer gating.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            pix_q <= '0;
        end else begin
            hs_q  <= hs_dly;
            vs_q  <= vs_dly;
            pix_q <= blank_dly ? pix_in : rgb444_t'('0);
        end
    end

    assign bus.DrawX       = hc;
    assign bus.DrawY       = vc;
    assign bus.blank       = blank_raw;
    assign bus.frame_start = (hc == coord_t'(0)) && (vc == coord_t'(0));
    assign bus.line_start  = (hc == coord_t'(0));
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.red         = pix_q.r;
    assign bus.green       = pix_q.g;
    assign bus.blue        = pix_q.b;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Purpose: directed checks of scan timing, pin alignment and reset for three driver instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_scan_driver;

    logic vga_clk = 1'b0;
    logic rst_a   = 1'b1;
    logic rst_c   = 1'b1;
    int   n_chk   = 0;
    int   n_fail  = 0;
    bit   b_done  = 1'b0;

    vga_scan_if bus_a ();
    vga_scan_if bus_b ();
    vga_scan_if bus_c ();

    // Full-size timing, single-stage renderer.
    vga_scan_driver #(.PIPE_DLY(1)) dut_a (.vga_clk(vga_clk), .reset(rst_a), .bus(bus_a));
    // Full-size timing, three-stage renderer.
    vga_scan_driver #(.PIPE_DLY(3)) dut_b (.vga_clk(vga_clk), .reset(rst_a), .bus(bus_b));
    // Miniature raster (24 x 10) so whole frames fit in a short run.
    vga_scan_driver #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_ACTIVE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DLY(1)
    ) dut_c (.vga_clk(vga_clk), .reset(rst_c), .bus(bus_c));

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int         k;
        int         x;
        int         y;
        logic       fs;
        logic       ls;
        logic       bl;
        logic       hs;
        logic       vs;
        logic [3:0] c;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int k, int x, int y, logic fs, logic ls, logic bl,
                                logic hs, logic vs, logic [3:0] c);
        vec_t v;
        v.k = k; v.x = x; v.y = y; v.fs = fs; v.ls = ls; v.bl = bl;
        v.hs = hs; v.vs = vs; v.c = c;
        return v;
    endfunction

    // Renderer colour pattern for dut_b, a pure function of the column.
    function automatic logic [11:0] fpix(int x);
        logic [9:0] xv;
        xv = 10'(x);
        return {xv[3:0], xv[7:4], 2'b01, xv[9:8]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // dut_b: renderer model with 3-clock latency, pins checked every clock.
    initial begin
        int xm, ym;
        logic [11:0] pe;
        logic        he;
        {bus_b.red_in, bus_b.green_in, bus_b.blue_in} = 12'hABC;
        @(negedge rst_a);
        #2;
        for (int k = 0; k <= 1700; k++) begin
            if (k > 0) begin
                @(posedge vga_clk);
                #2;
            end
            if (k >= 3) {bus_b.red_in, bus_b.green_in, bus_b.blue_in} = fpix((k - 3) % 800);
            else        {bus_b.red_in, bus_b.green_in, bus_b.blue_in} = 12'hABC;
            pe = 12'h000;
            he = 1'b1;
            if (k >= 4) begin
                xm = (k - 4) % 800;
                ym = ((k - 4) / 800) % 525;
                pe = (xm < 640 && ym < 480) ? fpix(xm) : 12'h000;
                he = !(xm >= 656 && xm < 752);
            end
            chk($sformatf("b_rgb k=%0d", k), 32'({bus_b.red, bus_b.green, bus_b.blue}), 32'(pe));
            chk($sformatf("b_hs k=%0d", k), 32'(bus_b.hs), 32'(he));
        end
        b_done = 1'b1;
    end

    initial begin
        int cyc, hs_low, first_low_x;
        int xp, yp, last_fs, fs_cnt, ls_cnt;
        int vs_cnt[2];
        int bl_cnt[2];
        logic [3:0] re;
        logic       hse, vse;

        bus_a.red_in = 4'hF; bus_a.green_in = 4'hF; bus_a.blue_in = 4'hF;
        bus_c.red_in = 4'hF; bus_c.green_in = 4'hF; bus_c.blue_in = 4'hF;

        //          k    x    y   fs ls bl hs vs  rgb
        vt.push_back(mk(0,   0,   0, 1, 1, 1, 1, 1, 4'h0));
        vt.push_back(mk(1,   1,   0, 0, 0, 1, 1, 1, 4'h0));
        vt.push_back(mk(2,   2,   0, 0, 0, 1, 1, 1, 4'hF));
        vt.push_back(mk(639, 639, 0, 0, 0, 1, 1, 1, 4'hF));
        vt.push_back(mk(640, 640, 0, 0, 0, 0, 1, 1, 4'hF));
        vt.push_back(mk(641, 641, 0, 0, 0, 0, 1, 1, 4'hF));
        vt.push_back(mk(642, 642, 0, 0, 0, 0, 1, 1, 4'h0));
        vt.push_back(mk(657, 657, 0, 0, 0, 0, 1, 1, 4'h0));
        vt.push_back(mk(658, 658, 0, 0, 0, 0, 0, 1, 4'h0));
        vt.push_back(mk(753, 753, 0, 0, 0, 0, 0, 1, 4'h0));
        vt.push_back(mk(754, 754, 0, 0, 0, 0, 1, 1, 4'h0));
        vt.push_back(mk(799, 799, 0, 0, 0, 0, 1, 1, 4'h0));
        vt.push_back(mk(800, 0,   1, 0, 1, 1, 1, 1, 4'h0));
        vt.push_back(mk(801, 1,   1, 0, 0, 1, 1, 1, 4'h0));
        vt.push_back(mk(802, 2,   1, 0, 0, 1, 1, 1, 4'hF));

        // Held in reset: counters at origin, pins idle.
        repeat (5) @(posedge vga_clk);
        #2;
        chk("a_rst_drawx", 32'(bus_a.DrawX), 0);
        chk("a_rst_hs", 32'(bus_a.hs), 1);
        chk("a_rst_vs", 32'(bus_a.vs), 1);
        chk("a_rst_rgb", 32'({bus_a.red, bus_a.green, bus_a.blue}), 0);

        @(negedge vga_clk);
        rst_a = 1'b0;
        cyc = 0;
        foreach (vt[i]) begin
            if (vt[i].k == 0) #2;
            else begin
                repeat (vt[i].k - cyc) @(posedge vga_clk);
                #2;
            end
            cyc = vt[i].k;
            chk($sformatf("a_drawx k=%0d", cyc), 32'(bus_a.DrawX), 32'(vt[i].x));
            chk($sformatf("a_drawy k=%0d", cyc), 32'(bus_a.DrawY), 32'(vt[i].y));
            chk($sformatf("a_frame_start k=%0d", cyc), 32'(bus_a.frame_start), 32'(vt[i].fs));
            chk($sformatf("a_line_start k=%0d", cyc), 32'(bus_a.line_start), 32'(vt[i].ls));
            chk($sformatf("a_blank k=%0d", cyc), 32'(bus_a.blank), 32'(vt[i].bl));
            chk($sformatf("a_hs k=%0d", cyc), 32'(bus_a.hs), 32'(vt[i].hs));
            chk($sformatf("a_vs k=%0d", cyc), 32'(bus_a.vs), 32'(vt[i].vs));
            chk($sformatf("a_red k=%0d", cyc), 32'(bus_a.red), 32'(vt[i].c));
            chk($sformatf("a_rgb k=%0d", cyc), 32'({bus_a.green, bus_a.blue}), 32'({vt[i].c, vt[i].c}));
        end

        // Second line: hsync pulse width and position on dut_a.
        hs_low = 0;
        first_low_x = -1;
        for (int k = 803; k < 1603; k++) begin
            @(posedge vga_clk);
            #2;
            if (bus_a.hs == 1'b0) begin
                if (first_low_x < 0) first_low_x = int'(bus_a.DrawX);
                hs_low++;
            end
        end
        chk("a_hs_low_count", 32'(hs_low), 96);
        chk("a_hs_first_low_drawx", 32'(first_low_x), 658);

        // Miniature raster: two full frames then into a third.
        last_fs = -1; fs_cnt = 0; ls_cnt = 0;
        vs_cnt[0] = 0; vs_cnt[1] = 0; bl_cnt[0] = 0; bl_cnt[1] = 0;
        @(negedge vga_clk);
        rst_c = 1'b0;
        #2;
        for (int kc = 0; kc <= 668; kc++) begin
            if (kc > 0) begin
                @(posedge vga_clk);
                #2;
            end
            chk($sformatf("c_drawx k=%0d", kc), 32'(bus_c.DrawX), 32'(kc % 24));
            chk($sformatf("c_drawy k=%0d", kc), 32'(bus_c.DrawY), 32'((kc / 24) % 10));
            re = 4'h0; hse = 1'b1; vse = 1'b1;
            if (kc >= 2) begin
                xp = (kc - 2) % 24;
                yp = ((kc - 2) / 24) % 10;
                re  = (xp < 16 && yp < 6) ? 4'hF : 4'h0;
                hse = !(xp >= 18 && xp < 22);
                vse = !(yp >= 7 && yp < 9);
            end
            chk($sformatf("c_rgb k=%0d", kc), 32'({bus_c.red, bus_c.green, bus_c.blue}), 32'({re, re, re}));
            chk($sformatf("c_hs k=%0d", kc), 32'(bus_c.hs), 32'(hse));
            chk($sformatf("c_vs k=%0d", kc), 32'(bus_c.vs), 32'(vse));
            if (kc < 480) begin
                if (bus_c.blank) bl_cnt[kc / 240]++;
                if (!bus_c.vs) vs_cnt[kc / 240]++;
                if (bus_c.line_start) ls_cnt++;
            end
            if (kc <= 480 && bus_c.frame_start) begin
                fs_cnt++;
                if (last_fs >= 0) chk($sformatf("c_frame_period k=%0d", kc), 32'(kc - last_fs), 240);
                last_fs = kc;
            end
        end
        chk("c_frame_start_count", 32'(fs_cnt), 3);
        chk("c_line_start_count", 32'(ls_cnt), 20);
        chk("c_vs_low_frame0", 32'(vs_cnt[0]), 48);
        chk("c_vs_low_frame1", 32'(vs_cnt[1]), 48);
        chk("c_blank_frame0", 32'(bl_cnt[0]), 96);
        chk("c_blank_frame1", 32'(bl_cnt[1]), 96);

        // Reset inside both sync pulses: pins go idle in the same cycle.
        #1;
        rst_c = 1'b1;
        #1;
        chk("c_midrst_hs", 32'(bus_c.hs), 1);
        chk("c_midrst_vs", 32'(bus_c.vs), 1);
        chk("c_midrst_rgb", 32'({bus_c.red, bus_c.green, bus_c.blue}), 0);
        chk("c_midrst_drawx", 32'(bus_c.DrawX), 0);
        chk("c_midrst_drawy", 32'(bus_c.DrawY), 0);
        @(negedge vga_clk);
        rst_c = 1'b0;
        #1;
        chk("c_rel_frame_start", 32'(bus_c.frame_start), 1);
        chk("c_rel_line_start", 32'(bus_c.line_start), 1);
        chk("c_rel_blank", 32'(bus_c.blank), 1);
        @(posedge vga_clk);
        #2;
        chk("c_rel1_drawx", 32'(bus_c.DrawX), 1);
        chk("c_rel1_drawy", 32'(bus_c.DrawY), 0);
        chk("c_rel1_hs", 32'(bus_c.hs), 1);
        chk("c_rel1_vs", 32'(bus_c.vs), 1);
        chk("c_rel1_rgb", 32'({bus_c.red, bus_c.green, bus_c.blue}), 0);
        @(posedge vga_clk);
        #2;
        chk("c_rel2_hs", 32'(bus_c.hs), 1);
        chk("c_rel2_vs", 32'(bus_c.vs), 1);
        chk("c_rel2_rgb", 32'({bus_c.red, bus_c.green, bus_c.blue}), 32'h0FFF);

        wait (b_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
